rx_plateau_detect: RTL and testbench

- Packet-detect stage directly downstream of the moving-sum accumulators in the OFDM 802.22 receiver front end.
- Consumes two 26-bit signed window sums per enabled sample:
  - corr_sum: delayed-autocorrelation magnitude sum.
  - pow_sum: received-power sum.
- Declares a preamble when corr_sum > (THR_NUM/8)·pow_sum and pow_sum > PWR_MIN hold for PLATEAU_LEN consecutive enabled samples.
- On detection, emits a one-clock det_pulse and then holds off re-triggering so the downstream coarse-timing/CFO stage sees a single event per preamble.

---
 rtl/rx_sync_pkg.sv | 23 ++
 rtl/rx_plateau_detect_if.sv | 25 ++
 rtl/rx_metric_cmp.sv | 43 ++++
 rtl/rx_plateau_detect.sv | 103 ++++++++++
 tb/tb_rx_plateau_detect.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/rx_sync_pkg.sv
// Shared definitions for the receiver sync/packet-detect stages.
// Widths of the accumulator sums, threshold scaling and detect FSM encoding.
package rx_sync_pkg;

  localparam int unsigned SUM_W         = 26;
  localparam int unsigned THR_FRAC_BITS = 3;
  localparam int unsigned THR_W         = 4;
  localparam int unsigned LHS_W         = SUM_W + THR_FRAC_BITS;
  localparam int unsigned RHS_W         = SUM_W + THR_W;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPlateau = 2'd1,
    StDetect  = 2'd2,
    StHoldoff = 2'd3
  } det_state_e;

  // Accumulators can go briefly negative at start-up; treat that as zero energy.
  function automatic logic [SUM_W-1:0] clamp_neg(input logic signed [SUM_W-1:0] x);
    return x[SUM_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/rx_plateau_detect_if.sv
// Sample stream in / detection status out for the plateau detector.
interface rx_plateau_detect_if
  import rx_sync_pkg::*;
#(
  parameter int unsigned CNT_W = 11
) ();

  logic                    ena;
  logic signed [SUM_W-1:0] corr_sum;
  logic signed [SUM_W-1:0] pow_sum;
  logic                    det_pulse;
  logic                    busy;
  logic [CNT_W-1:0]        plateau_cnt;

  modport master (
    output ena, corr_sum, pow_sum,
    input  det_pulse, busy, plateau_cnt
  );

  modport slave (
    input  ena, corr_sum, pow_sum,
    output det_pulse, busy, plateau_cnt
  );

endinterface

// File: rtl/rx_metric_cmp.sv
// Clamp, scale and compare of a correlation sum against a fraction of a power sum.
// Registered hit flag advances only on enabled samples.
module rx_metric_cmp
  import rx_sync_pkg::*;
#(
  parameter int unsigned THR_NUM = 6,
  parameter int unsigned PWR_MIN = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena_i,
  input  logic signed [SUM_W-1:0] corr_sum_i,
  input  logic signed [SUM_W-1:0] pow_sum_i,
  output logic                    hit_o
);

  logic [SUM_W-1:0] corr_c;
  logic [SUM_W-1:0] pow_c;
  logic [LHS_W-1:0] lhs;
  logic [RHS_W-1:0] rhs;
  logic             hit_d;
  logic             hit_q;

  // corr*8 > pow*THR_NUM is corr > (THR_NUM/8)*pow without a divider; both strict.
  always_comb begin
    corr_c = clamp_neg(corr_sum_i);
    pow_c  = clamp_neg(pow_sum_i);
    lhs    = {corr_c, {THR_FRAC_BITS{1'b0}}};
    rhs    = RHS_W'(pow_c) * RHS_W'(THR_NUM);
    hit_d  = (RHS_W'(lhs) > rhs) && (pow_c > SUM_W'(PWR_MIN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= 1'b0;
    end else if (ena_i) begin
      hit_q <= hit_d;
    end
  end

  assign hit_o = hit_q;

endmodule

// File: rtl/rx_plateau_detect.sv
// Preamble plateau detector: counts consecutive qualifying samples, emits one
// detection strobe, then holds off re-triggering for a fixed number of samples.
module rx_plateau_detect
  import rx_sync_pkg::*;
#(
  parameter int unsigned PLATEAU_LEN = 64,
  parameter int unsigned HOLDOFF_LEN = 1024,
  parameter int unsigned THR_NUM     = 6,
  parameter int unsigned PWR_MIN     = 1024,
  parameter int unsigned CNT_W       = 11
) (
  input  logic               clk,
  input  logic               rst,
  rx_plateau_detect_if.slave bus
);

  localparam logic [CNT_W-1:0] PlatLast = CNT_W'(PLATEAU_LEN - 1);
  localparam logic [CNT_W-1:0] PlatFull = CNT_W'(PLATEAU_LEN);
  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLDOFF_LEN);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  logic             hit;
  det_state_e       state_q;
  logic [CNT_W-1:0] plateau_cnt_q;
  logic [CNT_W-1:0] holdoff_cnt_q;
  logic             det_pulse_q;
  logic             busy_q;

  rx_metric_cmp #(
    .THR_NUM (THR_NUM),
    .PWR_MIN (PWR_MIN)
  ) u_metric_cmp (
    .clk        (clk),
    .rst        (rst),
    .ena_i      (bus.ena),
    .corr_sum_i (bus.corr_sum),
    .pow_sum_i  (bus.pow_sum),
    .hit_o      (hit)
  );

  // det_pulse clears on every clock so it stays one clk wide even with ena low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      plateau_cnt_q <= '0;
      holdoff_cnt_q <= '0;
      det_pulse_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      det_pulse_q <= 1'b0;
      if (bus.ena) begin
        unique case (state_q)
          StIdle: begin
            if (hit) begin
              state_q       <= StPlateau;
              busy_q        <= 1'b1;
              plateau_cnt_q <= CntOne;
            end else begin
              plateau_cnt_q <= '0;
            end
          end
          StPlateau: begin
            if (!hit) begin
              state_q       <= StIdle;
              busy_q        <= 1'b0;
              plateau_cnt_q <= '0;
            end else if (plateau_cnt_q == PlatLast) begin
              state_q       <= StDetect;
              det_pulse_q   <= 1'b1;
              plateau_cnt_q <= PlatFull;
            end else begin
              plateau_cnt_q <= plateau_cnt_q + CntOne;
            end
          end
          StDetect: begin
            state_q       <= StHoldoff;
            holdoff_cnt_q <= HoldLoad;
            plateau_cnt_q <= '0;
          end
          StHoldoff: begin
            plateau_cnt_q <= '0;
            if (holdoff_cnt_q == CntOne) begin
              state_q       <= StIdle;
              busy_q        <= 1'b0;
              holdoff_cnt_q <= '0;
            end else begin
              holdoff_cnt_q <= holdoff_cnt_q - CntOne;
            end
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.det_pulse   = det_pulse_q;
  assign bus.busy        = busy_q;
  assign bus.plateau_cnt = plateau_cnt_q;

endmodule

// File: tb/tb_rx_plateau_detect.sv
// Randomized and directed bench for rx_plateau_detect against a sample-count model.
module tb_rx_plateau_detect;

  localparam int PLAT = 64;
  localparam int HOLD = 1024;
  localparam int THR  = 6;
  localparam int PMIN = 1024;
  localparam int CW   = 11;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  bit   chk_en;

  rx_plateau_detect_if #(.CNT_W(CW)) bus ();

  rx_plateau_detect #(
    .PLATEAU_LEN (PLAT),
    .HOLDOFF_LEN (HOLD),
    .THR_NUM     (THR),
    .PWR_MIN     (PMIN),
    .CNT_W       (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: run = consecutive qualifying samples seen by the decision stage,
  // block = enabled samples still to be swallowed after a detection (detect + holdoff).
  int m_run;
  int m_block;
  bit m_hit;
  bit m_det;

  function automatic bit qual(input logic signed [25:0] c, input logic signed [25:0] p);
    longint ci;
    longint pi;
    ci = (c < 0) ? 0 : longint'(c);
    pi = (p < 0) ? 0 : longint'(p);
    return (ci * 8 > pi * THR) && (pi > PMIN);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_block = 0; m_hit = 0; m_det = 0;
    end else begin
      m_det = 0;
      if (bus.ena) begin
        if (m_block > 0) begin
          m_block--;
          m_run = 0;
        end else if (m_hit) begin
          m_run++;
          if (m_run == PLAT) begin
            m_det   = 1;
            m_block = HOLD + 1;
          end
        end else begin
          m_run = 0;
        end
        m_hit = qual(bus.corr_sum, bus.pow_sum);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_busy;
      exp_busy = (m_run > 0) || (m_block > 0);
      checks++;
      if (bus.det_pulse !== m_det || bus.busy !== exp_busy || int'(bus.plateau_cnt) != m_run
          || $isunknown(bus.plateau_cnt)) begin
        failures++;
        $display("FAIL model_cmp t=%0t det=%b exp=%b busy=%b exp=%b cnt=%0d exp=%0d",
                 $time, bus.det_pulse, m_det, bus.busy, exp_busy, bus.plateau_cnt, m_run);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Drive a constant pair for n cycles; ena_per=0 means random enable.
  task automatic run_seg(input int c, input int p, input int n, input int ena_per,
                         output int first_det, output int ndet, output int max_cnt,
                         output int cnt_first, output int busy_low);
    first_det = 0; ndet = 0; max_cnt = 0; cnt_first = -1; busy_low = 0;
    for (int k = 1; k <= n; k++) begin
      bus.ena      = (ena_per == 0) ? ($urandom_range(0, 3) != 0) : (((k - 1) % ena_per) == 0);
      bus.corr_sum = 26'(c);
      bus.pow_sum  = 26'(p);
      @(negedge clk);
      if (bus.det_pulse) begin
        ndet++;
        if (first_det == 0) first_det = k;
      end
      if (int'(bus.plateau_cnt) > max_cnt) max_cnt = int'(bus.plateau_cnt);
      if (k == 1) cnt_first = int'(bus.plateau_cnt);
      if (!bus.busy && busy_low == 0) busy_low = k;
    end
  endtask

  task automatic do_rst(input string name);
    rst     = 1'b1;
    bus.ena = 1'b1;
    @(negedge clk);
    check({name, "_det"}, int'(bus.det_pulse), 0);
    check({name, "_busy"}, int'(bus.busy), 0);
    check({name, "_cnt"}, int'(bus.plateau_cnt), 0);
    rst = 1'b0;
  endtask

  initial begin
    int fd, nd, mc, cf, bl;
    int kind, n, pw, cr, m, em;
    checks = 0; failures = 0; chk_en = 0;
    rst = 1'b1; bus.ena = 1'b0; bus.corr_sum = '0; bus.pow_sum = '0;
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_cnt", int'(bus.plateau_cnt), 0);
    rst = 1'b0;

    run_seg(0, 0, 200, 1, fd, nd, mc, cf, bl);
    check("idle_ndet", nd, 0);
    check("idle_maxcnt", mc, 0);

    run_seg(16000, 20000, 65, 1, fd, nd, mc, cf, bl);
    check("nom_first_det", fd, 65);
    check("nom_ndet", nd, 1);
    check("nom_cnt_sat", mc, 64);
    run_seg(0, 0, 1100, 1, fd, nd, mc, cf, bl);
    check("nom_holdoff_ndet", nd, 0);
    check("nom_busy_fall", bl, 1025);

    run_seg(15000, 20000, 100, 1, fd, nd, mc, cf, bl);
    check("thr_equal_cnt", mc, 0);
    run_seg(1000, 1024, 100, 1, fd, nd, mc, cf, bl);
    check("pmin_equal_cnt", mc, 0);
    run_seg(15001, 20000, 65, 1, fd, nd, mc, cf, bl);
    check("thr_plus1_det", fd, 65);
    run_seg(0, 0, 1100, 1, fd, nd, mc, cf, bl);
    check("thr_busy_fall", bl, 1025);

    run_seg(16000, 20000, 63, 1, fd, nd, mc, cf, bl);
    check("brk_run1_ndet", nd, 0);
    check("brk_run1_cnt", mc, 62);
    run_seg(0, 20000, 1, 1, fd, nd, mc, cf, bl);
    check("brk_peak", mc, 63);
    run_seg(16000, 20000, 65, 1, fd, nd, mc, cf, bl);
    check("brk_drop", cf, 0);
    check("brk_run2_det", fd, 65);
    check("brk_run2_ndet", nd, 1);
    run_seg(0, 0, 1100, 1, fd, nd, mc, cf, bl);

    run_seg(16000, 20000, 200, 3, fd, nd, mc, cf, bl);
    check("ena3_first_det", fd, 193);
    check("ena3_ndet", nd, 1);
    check("ena3_busy_in_holdoff", int'(bus.busy), 1);
    do_rst("rst_holdoff");

    run_seg(16000, 20000, 41, 1, fd, nd, mc, cf, bl);
    check("rst_plat_cnt", mc, 40);
    do_rst("rst_plateau");
    run_seg(16000, 20000, 65, 1, fd, nd, mc, cf, bl);
    check("post_rst_det", fd, 65);
    run_seg(0, 0, 1100, 1, fd, nd, mc, cf, bl);

    run_seg(-5, 20000, 100, 1, fd, nd, mc, cf, bl);
    check("neg_corr_cnt", mc, 0);
    check("neg_corr_ndet", nd, 0);

    for (int s = 0; s < 70; s++) begin
      kind = $urandom_range(0, 5);
      em   = ($urandom_range(0, 1) == 0) ? 0 : 1;
      case (kind)
        0: begin
          pw = $urandom_range(2000, 1000000);
          cr = (pw * 3) / 4 + $urandom_range(1, 1000);
          n  = $urandom_range(40, 90);
          run_seg(cr, pw, n, em, fd, nd, mc, cf, bl);
        end
        1: begin
          m  = $urandom_range(256, 5000);
          cr = 3 * m + $urandom_range(0, 2) - 1;
          run_seg(cr, 4 * m, $urandom_range(1, 30), em, fd, nd, mc, cf, bl);
        end
        2: run_seg(0, 0, $urandom_range(1, 1200), em, fd, nd, mc, cf, bl);
        3: run_seg(-$urandom_range(1, 1000), $urandom_range(0, 50000), $urandom_range(1, 20),
                   em, fd, nd, mc, cf, bl);
        4: run_seg(2000, $urandom_range(1023, 1026), $urandom_range(1, 70), em,
                   fd, nd, mc, cf, bl);
        default: do_rst("rand_rst");
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
